mesh_term_rx: RTL and testbench
===============================

Name: mesh_term_rx

Overview:
- Synthesizable terminal receiver for one edge port of the mesh_gnrtr router mesh. It is the consuming end of the mesh's pending/pop output interface.
- It watches pndng/data_out, pops packets, and checks that each packet's destination matches its own edge position.
- Accepted packets are buffered in a local FIFO with a valid/ready output. Misrouted packets are dropped and counted.
- Used as the RTL endpoint that replaces the bench monitor in system-level integration.

Parameters:
- pckg_sz, 40, packet width in bits.
- fifo_depth, 4, local accept-FIFO depth in packets (power of 2, ≥2).
- ROWS, 4, mesh rows.
- COLUMS, 4, mesh columns.
- self_row, 0, row id of this edge terminal (0..ROWS+1).
- self_col, 1, column id of this edge terminal (0..COLUMS+1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pndng  in  1  mesh port has a packet at data_out.
- data_out  in  pckg_sz  head packet from mesh port; valid while pndng=1.
- pop  out  1  one-cycle consume strobe to mesh port.
- rx_valid  out  1  local FIFO non-empty.
- rx_ready  in  1  consumer accepts rx_pkt this cycle.
- rx_pkt  out  pckg_sz  FIFO head packet, unmodified.
- rx_bcast  out  1  FIFO head was a broadcast packet.
- fifo_full  out  1  local FIFO holds fifo_depth packets.
- misroute_err  out  1  one-cycle pulse when a popped packet is dropped.
- pkt_cnt  out  16  accepted-packet counter, saturating.
- err_cnt  out  16  dropped-packet counter, saturating.

Behaviour:
- Packet fields:
  - [pckg_sz-1:pckg_sz-8] Nxt_jump (ignored).
  - [pckg_sz-9:pckg_sz-12] id_row.
  - [pckg_sz-13:pckg_sz-16] id_col.
  - [pckg_sz-17] mode (ignored).
  - [pckg_sz-18:0] payload.
- Broadcast: id_row==4'hF and id_col==4'hF.
- Reset (synchronous, active-high): pop, rx_valid, rx_bcast, fifo_full, misroute_err = 0; rx_pkt = 0; pkt_cnt, err_cnt = 0. The FIFO is emptied and the FSM goes to IDLE.
- FSM, two states:
  - IDLE: if pndng=1 and FIFO count < fifo_depth, assert pop for this cycle (combinational from state/pndng/count). data_out is captured into cap_reg on the same edge; go to CHECK. Otherwise stay in IDLE with pop=0.
  - CHECK: pop=0, so the mesh port can update pndng/data_out. Classify cap_reg:
    - Destination match (id_row==self_row and id_col==self_col) or broadcast: push {cap_reg, bcast} into the FIFO and increment pkt_cnt.
    - Otherwise: misroute_err=1 for this cycle, increment err_cnt, no push.
    - Always return to IDLE.
- Throughput: at most one packet per 2 cycles. pop is never high on two consecutive cycles.
- Latency: pop at cycle T → FIFO write at the T+1 edge → rx_valid=1 and rx_pkt valid in cycle T+2 (when the FIFO was empty).
- Output handshake:
  - The FIFO read occurs when rx_valid and rx_ready are both high. rx_pkt/rx_bcast show the registered head and are stable while rx_valid=1 and rx_ready=0.
  - rx_pkt = 0 when empty.
  - Ordering is strict FIFO.
- FIFO boundaries:
  - Push and pop in the same cycle: count unchanged, both take effect.
  - A push can never occur when full, because the IDLE gate reserves the slot.
  - A consumer read in the CHECK cycle is legal.
  - fifo_full is registered and equals (count==fifo_depth).
  - Pointers wrap modulo fifo_depth.
- Counters saturate at 16'hFFFF and do not wrap.
- Reset mid-operation: reset asserted in CHECK discards cap_reg (no push, no counter change, no misroute_err). Reset in IDLE forces pop=0 that cycle.
- pndng dropping in the CHECK cycle is legal. pop is never asserted while pndng=0.

Test Plan:
- Reset held 5 cycles, pndng=0 → pop=0 throughout; rx_valid=0; pkt_cnt=err_cnt=0; rx_pkt=0.
- self_row=1, self_col=0; present packet id_row=1, id_col=0, payload 22'h15A5A5 at cycle T with rx_ready=0 → pop=1 only at T; rx_valid=1 from T+2; rx_pkt equals the presented word; rx_bcast=0; pkt_cnt=1.
- Present id_row=2, id_col=3 → pop at T; misroute_err=1 at T+1 only; err_cnt=1; rx_valid stays 0.
- Present id_row=F, id_col=F → accepted; rx_bcast=1; pkt_cnt increments.
- rx_ready=0, pndng held 1 with 6 matching packets, fifo_depth=4:
  - Exactly 4 pops, spaced 2 cycles apart; fifo_full=1; pop stays 0.
  - Then rx_ready=1 → packets drain in order.
  - The remaining 2 are popped, and all 6 appear in send order.
- Reset asserted in the CHECK cycle of a matching packet → no push; pkt_cnt=0; rx_valid=0 after reset. A subsequent packet is processed normally.

Source files
------------

// File: rtl/mesh_term_rx.sv
// mesh_term_rx: mesh edge terminal; pops packets, keeps those addressed here (or broadcast) in a local FIFO,
// drops and counts the rest.
module mesh_term_rx #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int self_row   = 0,
    parameter int self_col   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pndng,
    input  logic [pckg_sz-1:0] data_out,
    output logic               pop,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [pckg_sz-1:0] rx_pkt,
    output logic               rx_bcast,
    output logic               fifo_full,
    output logic               misroute_err,
    output logic [15:0]        pkt_cnt,
    output logic [15:0]        err_cnt
);
    localparam int AW = $clog2(fifo_depth);
    localparam int CW = AW + 1;
    localparam logic [3:0] ROW_ID = 4'(self_row);
    localparam logic [3:0] COL_ID = 4'(self_col);

    if (self_row > ROWS + 1 || self_col > COLUMS + 1) begin : g_bad_pos
        $error("mesh_term_rx: terminal position outside the mesh edge ring");
    end

    typedef enum logic {IDLE, CHECK} state_t;

    state_t             state_q, state_d;
    logic [pckg_sz-1:0] cap_q, cap_d;
    logic [pckg_sz:0]   mem_q [fifo_depth];
    logic [pckg_sz:0]   mem_d [fifo_depth];
    logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               full_q, full_d;
    logic [15:0]        pkt_q, pkt_d, err_q, err_d;
    logic [3:0]         id_row, id_col;
    logic               bcast, accept, push, rd;

    assign id_row = cap_q[pckg_sz-9 -: 4];
    assign id_col = cap_q[pckg_sz-13 -: 4];
    assign bcast  = id_row == 4'hF && id_col == 4'hF;
    assign accept = bcast || (id_row == ROW_ID && id_col == COL_ID);

    // The IDLE gate on count reserves the FIFO slot, so a CHECK push never meets a full FIFO.
    always_comb begin
        pop          = !reset && state_q == IDLE && pndng && cnt_q < CW'(fifo_depth);
        push         = !reset && state_q == CHECK && accept;
        misroute_err = !reset && state_q == CHECK && !accept;
        rx_valid     = cnt_q != '0;
        rd           = rx_valid && rx_ready;
        rx_pkt       = rx_valid ? mem_q[rd_q][pckg_sz:1] : '0;
        rx_bcast     = rx_valid && mem_q[rd_q][0];
        state_d      = pop ? CHECK : IDLE;
        cap_d        = pop ? data_out : cap_q;
        mem_d        = mem_q;
        if (push) mem_d[wr_q] = {cap_q, bcast};
        wr_d         = push ? wr_q + AW'(1) : wr_q;
        rd_d         = rd ? rd_q + AW'(1) : rd_q;
        cnt_d        = cnt_q + CW'(push) - CW'(rd);
        full_d       = cnt_d == CW'(fifo_depth);
        pkt_d        = (push && pkt_q != 16'hFFFF) ? pkt_q + 16'd1 : pkt_q;
        err_d        = (misroute_err && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
        fifo_full    = full_q;
        pkt_cnt      = pkt_q;
        err_cnt      = err_q;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            state_q <= IDLE;
            cap_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            pkt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            pkt_q   <= pkt_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_mesh_term_rx.sv
// tb_mesh_term_rx: directed vector table, fill/drain and reset-in-CHECK sequences, then random traffic
// checked every cycle against a queue-based reference model.
module tb_mesh_term_rx;
    localparam int PW = 40;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset, pndng, pop, rx_valid, rx_ready, rx_bcast, fifo_full, misroute_err;
    logic [PW-1:0] data_out, rx_pkt;
    logic [15:0]   pkt_cnt, err_cnt;

    always #5 clk = ~clk;

    mesh_term_rx #(
        .pckg_sz(PW), .fifo_depth(DEPTH), .ROWS(4), .COLUMS(4), .self_row(1), .self_col(0)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .pop(pop),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_pkt(rx_pkt), .rx_bcast(rx_bcast),
        .fifo_full(fifo_full), .misroute_err(misroute_err), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    typedef struct {
        logic          rst, pn, rdy;
        logic [PW-1:0] d;
        logic          e_pop, e_valid, e_mis, e_bcast;
        logic [PW-1:0] e_pkt;
        int            e_pc, e_ec;
    } vec_t;

    int            vectors = 0, miscompares = 0, npop;
    logic [PW:0]   mq[$];
    logic [PW-1:0] src[$], sent[$], got[$];
    logic          m_pend;
    logic [PW-1:0] m_cap;
    int            m_pc, m_ec;
    logic          prev_pop;
    logic          s_pop, s_valid, s_mis, s_bcast, s_full;
    logic [PW-1:0] s_pkt;
    logic [15:0]   s_pc, s_ec;
    logic [PW-1:0] p1, p2, p3;
    vec_t          tbl[17];

    function automatic logic [PW-1:0] mk(input logic [3:0] row, input logic [3:0] col, input logic [22:0] pl);
        logic [PW-1:0] p;
        p = '0;
        p[PW-9 -: 4] = row;
        p[PW-13 -: 4] = col;
        p[22:0] = pl;
        return p;
    endfunction

    function automatic logic is_bc(input logic [PW-1:0] p);
        return p[PW-9 -: 8] == 8'hFF;
    endfunction

    function automatic logic is_acc(input logic [PW-1:0] p);
        return p[PW-9 -: 8] == 8'h10 || p[PW-9 -: 8] == 8'hFF;
    endfunction

    function automatic logic [PW-1:0] rnd_pkt();
        logic [PW-1:0] p;
        int k;
        p = PW'({$urandom, $urandom});
        k = $urandom_range(0, 2);
        if (k == 0) p[PW-9 -: 8] = 8'h10;
        else if (k == 1) p[PW-9 -: 8] = 8'hFF;
        return p;
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic pn, input logic [PW-1:0] d, input logic rdy);
        logic e_pop, e_mis;
        logic [PW-1:0] e_pkt;
        reset = r; pndng = pn; data_out = d; rx_ready = rdy;
        @(negedge clk);
        e_pop = !r && !m_pend && pn && (mq.size() < DEPTH);
        e_mis = !r && m_pend && !is_acc(m_cap);
        e_pkt = mq.size() != 0 ? mq[0][PW:1] : '0;
        chk("pop", pop, e_pop);
        chk("rx_valid", rx_valid, mq.size() != 0);
        chk("rx_pkt", rx_pkt, e_pkt);
        chk("rx_bcast", rx_bcast, mq.size() != 0 ? mq[0][0] : 1'b0);
        chk("fifo_full", fifo_full, mq.size() == DEPTH);
        chk("misroute_err", misroute_err, e_mis);
        chk("pkt_cnt", pkt_cnt, m_pc);
        chk("err_cnt", err_cnt, m_ec);
        chk("pop_back_to_back", pop && prev_pop, 0);
        s_pop = pop; s_valid = rx_valid; s_mis = misroute_err; s_bcast = rx_bcast;
        s_full = fifo_full; s_pkt = rx_pkt; s_pc = pkt_cnt; s_ec = err_cnt;
        prev_pop = pop;
        @(posedge clk);
        if (r) begin
            mq.delete(); m_pend = 0; m_pc = 0; m_ec = 0;
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (m_pend) begin
                if (is_acc(m_cap)) begin
                    mq.push_back({m_cap, is_bc(m_cap)});
                    if (m_pc < 65535) m_pc++;
                end else if (m_ec < 65535) m_ec++;
            end
            m_pend = e_pop;
            m_cap = d;
        end
        #1;
    endtask

    task automatic src_cyc(input logic rdy);
        logic pn;
        pn = src.size() != 0;
        cyc(1'b0, pn, pn ? src[0] : '0, rdy);
        if (s_pop && src.size() != 0) begin npop++; void'(src.pop_front()); end
        if (s_valid && rdy) got.push_back(s_pkt);
    endtask

    function automatic vec_t v(input logic rst, pn, input logic [PW-1:0] d, input logic rdy,
                               input logic ep, ev, em, eb, input logic [PW-1:0] ek, input int pc, ec);
        vec_t t;
        t.rst = rst; t.pn = pn; t.d = d; t.rdy = rdy; t.e_pop = ep; t.e_valid = ev;
        t.e_mis = em; t.e_bcast = eb; t.e_pkt = ek; t.e_pc = pc; t.e_ec = ec;
        return t;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1; pndng = 0; data_out = '0; rx_ready = 0;
        prev_pop = 0; m_pend = 0; m_cap = '0; m_pc = 0; m_ec = 0;
        @(posedge clk); #1;
        p1 = mk(4'h1, 4'h0, 23'h15A5A5);
        p2 = mk(4'h2, 4'h3, 23'h000123);
        p3 = mk(4'hF, 4'hF, 23'h000007);
        for (int i = 0; i < 5; i++) tbl[i] = v(1, 0, '0, 0, 0, 0, 0, 0, '0, 0, 0);
        tbl[5]  = v(0, 1, p1, 0, 1, 0, 0, 0, '0, 0, 0);
        tbl[6]  = v(0, 0, p1, 0, 0, 0, 0, 0, '0, 0, 0);
        tbl[7]  = v(0, 0, '0, 0, 0, 1, 0, 0, p1, 1, 0);
        tbl[8]  = v(0, 0, '0, 1, 0, 1, 0, 0, p1, 1, 0);
        tbl[9]  = v(0, 1, p2, 0, 1, 0, 0, 0, '0, 1, 0);
        tbl[10] = v(0, 0, p2, 0, 0, 0, 1, 0, '0, 1, 0);
        tbl[11] = v(0, 0, '0, 0, 0, 0, 0, 0, '0, 1, 1);
        tbl[12] = v(0, 1, p3, 0, 1, 0, 0, 0, '0, 1, 1);
        tbl[13] = v(0, 0, p3, 0, 0, 0, 0, 0, '0, 1, 1);
        tbl[14] = v(0, 0, '0, 0, 0, 1, 0, 1, p3, 2, 1);
        tbl[15] = v(0, 0, '0, 1, 0, 1, 0, 1, p3, 2, 1);
        tbl[16] = v(0, 0, '0, 0, 0, 0, 0, 0, '0, 2, 1);
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].rst, tbl[i].pn, tbl[i].d, tbl[i].rdy);
            chk("tbl_pop", s_pop, tbl[i].e_pop);
            chk("tbl_valid", s_valid, tbl[i].e_valid);
            chk("tbl_mis", s_mis, tbl[i].e_mis);
            chk("tbl_bcast", s_bcast, tbl[i].e_bcast);
            chk("tbl_pkt", s_pkt, tbl[i].e_pkt);
            chk("tbl_pkt_cnt", s_pc, tbl[i].e_pc);
            chk("tbl_err_cnt", s_ec, tbl[i].e_ec);
        end

        src.delete(); sent.delete(); got.delete(); npop = 0;
        for (int i = 0; i < 6; i++) src.push_back(mk(4'h1, 4'h0, 23'(i + 100)));
        sent = src;
        for (int i = 0; i < 20; i++) src_cyc(1'b0);
        chk("fill_pops", npop, 4);
        chk("fill_full", s_full, 1);
        chk("fill_left", src.size(), 2);
        for (int i = 0; i < 40 && got.size() < 6; i++) src_cyc(1'b1);
        chk("drain_count", got.size(), 6);
        for (int i = 0; i < got.size(); i++) chk("drain_order", got[i], sent[i]);

        cyc(0, 0, '0, 1); cyc(0, 0, '0, 1);
        cyc(0, 1, p1, 0);
        chk("rst_chk_pop", s_pop, 1);
        cyc(1, 0, p1, 0);
        chk("rst_chk_mis", s_mis, 0);
        cyc(0, 0, '0, 0);
        chk("rst_chk_valid", s_valid, 0);
        chk("rst_chk_pc", s_pc, 0);
        cyc(0, 1, p1, 0); cyc(0, 0, p1, 0); cyc(0, 0, '0, 0);
        chk("after_rst_valid", s_valid, 1);
        chk("after_rst_pkt", s_pkt, p1);
        chk("after_rst_pc", s_pc, 1);

        src.delete();
        for (int i = 0; i < 400; i++) begin
            logic r, pn;
            if (src.size() == 0 && $urandom_range(0, 2) == 0) src.push_back(rnd_pkt());
            r = $urandom_range(0, 59) == 0;
            pn = src.size() != 0 && $urandom_range(0, 3) != 0;
            cyc(r, pn, pn ? src[0] : PW'({$urandom, $urandom}), 1'($urandom_range(0, 1)));
            if (s_pop && src.size() != 0) void'(src.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
